pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Arbitrates three events each cycle: a data-memory wait freezes the whole
// pipe, a taken branch flushes the two younger stages, and a load-use hazard
// holds IF/ID for one cycle while a bubble enters EXE. Forwarding selects
// for both EXE operands are computed alongside. Only the wait/stall
// bookkeeping is registered; every control output is combinational.
module pipe_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,

  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rw,
  input  logic        ex_reg_write,
  input  logic        ex_memtoreg,

  input  logic [4:0]  mem_rw,
  input  logic        mem_reg_write,
  input  logic        mem_memtoreg,

  input  logic [4:0]  wb_rw,
  input  logic        wb_reg_write,

  input  logic        mem_req,
  input  logic        dmem_ready,
  input  logic        branch_taken,

  output logic        pc_wr,
  output logic        if_id_wrn,
  output logic        id_exe_wrn,
  output logic        exe_mem_wrn,
  output logic        mem_wb_wrn,

  output logic        if_id_flush,
  output logic        id_exe_flush,
  output logic        mem_wb_flush,

  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,

  output logic        state,
  output logic [15:0] stall_cnt,
  output logic        mem_timeout
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  // The wait counter is 8 bits wide, so the limit is compared in that width.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state_q;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       mem_freeze;
  logic       load_use;

  assign state = state_q;

  // Picks the EXE operand source; the MEM stage is younger so it wins over WB,
  // a load in MEM has no result on busw yet, and $0 is never forwarded.
  function automatic logic [1:0] fwd_select(input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (mem_reg_write && !mem_memtoreg && (mem_rw != 5'd0) && (mem_rw == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rw != 5'd0) && (wb_rw == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // A freeze happens when RUN sees a new unfinished access, or while MEM_WAIT
  // is still waiting; in MEM_WAIT only dmem_ready matters.
  always_comb begin
    mem_freeze = 1'b0;
    if (state_q == MEM_WAIT) begin
      mem_freeze = !dmem_ready;
    end else begin
      mem_freeze = mem_req && !dmem_ready;
    end
  end

  // Raw load-use detection; the output logic gives it the lowest priority.
  always_comb begin
    load_use = 1'b0;
    if (ex_memtoreg && ex_reg_write && (ex_rw != 5'd0)) begin
      load_use = (id_uses_rs && (id_rs == ex_rw)) ||
                 (id_uses_rt && (id_rt == ex_rw));
    end
  end

  // Saturating next value of the wait counter.
  always_comb begin
    wait_inc = wait_cnt;
    if (wait_cnt != 8'hFF) begin
      wait_inc = wait_cnt + 8'd1;
    end
  end

  // Stage enables, flushes and forwarding: memory wait beats branch beats
  // load-use, and everything is held quiet while reset is asserted.
  always_comb begin
    pc_wr        = 1'b0;
    if_id_wrn    = 1'b0;
    id_exe_wrn   = 1'b0;
    exe_mem_wrn  = 1'b0;
    mem_wb_wrn   = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    mem_wb_flush = 1'b0;
    fwd_a        = FWD_REGFILE;
    fwd_b        = FWD_REGFILE;

    if (reset) begin
      fwd_a = fwd_select(ex_rs);
      fwd_b = fwd_select(ex_rt);

      if (mem_freeze) begin
        mem_wb_flush = 1'b1;
      end else begin
        pc_wr       = 1'b1;
        if_id_wrn   = 1'b1;
        id_exe_wrn  = 1'b1;
        exe_mem_wrn = 1'b1;
        mem_wb_wrn  = 1'b1;

        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
        end else if (load_use) begin
          pc_wr        = 1'b0;
          if_id_wrn    = 1'b0;
          id_exe_flush = 1'b1;
        end
      end
    end
  end

  // RUN/MEM_WAIT sequencing with wait counting, sticky timeout and the
  // saturating stall counter; reset drops any partial wait.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt    <= 8'd0;
      stall_cnt   <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      if (!pc_wr && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end

      unique case (state_q)
        RUN: begin
          wait_cnt <= 8'd0;
          if (mem_freeze) begin
            state_q <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_q  <= RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT_CNT) begin
              mem_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with TIMEOUT=4: directed scenarios for the
// hazard, forwarding, wait, timeout and reset behaviour, then a randomized run.
// A rule-level model predicts every output each cycle.
module tb_pipe_ctrl;

  localparam int TIMEOUT = 4;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic [4:0]  ex_rs, ex_rt, ex_rw;
  logic        ex_reg_write, ex_memtoreg;
  logic [4:0]  mem_rw;
  logic        mem_reg_write, mem_memtoreg;
  logic [4:0]  wb_rw;
  logic        wb_reg_write;
  logic        mem_req, dmem_ready, branch_taken;
  logic        pc_wr, if_id_wrn, id_exe_wrn, exe_mem_wrn, mem_wb_wrn;
  logic        if_id_flush, id_exe_flush, mem_wb_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        state;
  logic [15:0] stall_cnt;
  logic        mem_timeout;

  int compared;
  int mismatched;

  // Model state: whether a memory wait is in progress, how many waiting
  // cycles have elapsed, stalled cycles so far and the sticky timeout.
  bit m_waiting;
  int m_waited;
  int m_stalls;
  bit m_timeout;

  // Model predictions for the current cycle.
  bit       e_frozen;
  bit [4:0] e_en;
  bit [2:0] e_fl;
  bit [1:0] e_fa, e_fb;

  pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw),
    .ex_reg_write(ex_reg_write), .ex_memtoreg(ex_memtoreg),
    .mem_rw(mem_rw), .mem_reg_write(mem_reg_write), .mem_memtoreg(mem_memtoreg),
    .wb_rw(wb_rw), .wb_reg_write(wb_reg_write),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_wr(pc_wr), .if_id_wrn(if_id_wrn), .id_exe_wrn(id_exe_wrn),
    .exe_mem_wrn(exe_mem_wrn), .mem_wb_wrn(mem_wb_wrn),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush), .mem_wb_flush(mem_wb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on a difference counts and reports it.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Quiet pipeline: no hazards, memory ready, reset released.
  task automatic applyStimulus();
    reset         = 1'b1;
    id_rs         = 5'd0;  id_rt = 5'd0;
    id_uses_rs    = 1'b0;  id_uses_rt = 1'b0;
    ex_rs         = 5'd0;  ex_rt = 5'd0;  ex_rw = 5'd0;
    ex_reg_write  = 1'b0;  ex_memtoreg = 1'b0;
    mem_rw        = 5'd0;  mem_reg_write = 1'b0;  mem_memtoreg = 1'b0;
    wb_rw         = 5'd0;  wb_reg_write = 1'b0;
    mem_req       = 1'b0;  dmem_ready = 1'b1;  branch_taken = 1'b0;
  endtask

  // Forwarding source chosen from the rules: busw from MEM when it holds a
  // non-load result for that register, else WB, else the register file.
  function automatic bit [1:0] modelFwd(input logic [4:0] src);
    if (mem_reg_write && !mem_memtoreg && mem_rw != 0 && mem_rw == src) return 2'd1;
    if (wb_reg_write && wb_rw != 0 && wb_rw == src) return 2'd2;
    return 2'd0;
  endfunction

  // Predicts this cycle's outputs from the current inputs and model state.
  task automatic predict();
    bit hazard;
    hazard = ex_memtoreg && ex_reg_write && ex_rw != 0 &&
             ((id_uses_rs && id_rs == ex_rw) || (id_uses_rt && id_rt == ex_rw));
    e_frozen = reset && (m_waiting ? !dmem_ready : (mem_req && !dmem_ready));
    e_en = 5'b00000;
    e_fl = 3'b000;
    e_fa = 2'd0;
    e_fb = 2'd0;
    if (reset) begin
      e_fa = modelFwd(ex_rs);
      e_fb = modelFwd(ex_rt);
      if (e_frozen) begin
        e_fl = 3'b001;
      end else if (branch_taken) begin
        e_en = 5'b11111;
        e_fl = 3'b110;
      end else if (hazard) begin
        e_en = 5'b00111;
        e_fl = 3'b010;
      end else begin
        e_en = 5'b11111;
      end
    end
  endtask

  // Lets inputs settle mid-cycle, then compares every output with the model.
  task automatic settleAndCheck(input string tag);
    #3;
    predict();
    checkOutput({tag, ".enables"},
                {11'd0, pc_wr, if_id_wrn, id_exe_wrn, exe_mem_wrn, mem_wb_wrn},
                {11'd0, e_en});
    checkOutput({tag, ".flushes"},
                {13'd0, if_id_flush, id_exe_flush, mem_wb_flush}, {13'd0, e_fl});
    checkOutput({tag, ".fwd_a"}, {14'd0, fwd_a}, {14'd0, e_fa});
    checkOutput({tag, ".fwd_b"}, {14'd0, fwd_b}, {14'd0, e_fb});
    checkOutput({tag, ".state"}, {15'd0, state}, {15'd0, m_waiting});
    checkOutput({tag, ".stall_cnt"}, stall_cnt, 16'(m_stalls));
    checkOutput({tag, ".mem_timeout"}, {15'd0, mem_timeout}, {15'd0, m_timeout});
  endtask

  // Advances one rising edge and moves the model on with the held inputs.
  task automatic clockEdge();
    @(posedge clock);
    if (!reset) begin
      m_waiting = 0;
      m_waited  = 0;
      m_stalls  = 0;
      m_timeout = 0;
    end else begin
      if (!e_en[4] && m_stalls < 65535) m_stalls++;
      if (e_frozen) begin
        if (m_waiting) begin
          if (m_waited < 255) m_waited++;
          if (m_waited >= TIMEOUT) m_timeout = 1;
        end
        m_waiting = 1;
      end else begin
        m_waiting = 0;
        m_waited  = 0;
      end
    end
    #1;
  endtask

  task automatic stepCycle(input string tag);
    settleAndCheck(tag);
    clockEdge();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    applyStimulus();
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    m_waiting = 0; m_waited = 0; m_stalls = 0; m_timeout = 0;

    // Reset held with a forwarding match present: everything stays quiet.
    mem_rw = 5'd7; ex_rs = 5'd7; mem_reg_write = 1'b1;
    settleAndCheck("rst_hold");
    checkOutput("rst_hold.pc_wr", {15'd0, pc_wr}, 16'd0);
    checkOutput("rst_hold.fwd_a", {14'd0, fwd_a}, 16'd0);
    clockEdge();
    applyStimulus();
    settleAndCheck("rst_state");
    checkOutput("rst_state.stall_cnt", stall_cnt, 16'd0);
    checkOutput("rst_state.state", {15'd0, state}, 16'd0);
    clockEdge();

    // Load-use for one cycle gives a single bubble.
    ex_memtoreg = 1'b1; ex_reg_write = 1'b1; ex_rw = 5'd5;
    id_uses_rs = 1'b1; id_rs = 5'd5;
    settleAndCheck("lu");
    checkOutput("lu.pc_wr", {15'd0, pc_wr}, 16'd0);
    checkOutput("lu.if_id_wrn", {15'd0, if_id_wrn}, 16'd0);
    checkOutput("lu.id_exe_flush", {15'd0, id_exe_flush}, 16'd1);
    clockEdge();
    applyStimulus();
    settleAndCheck("lu_after");
    checkOutput("lu_after.pc_wr", {15'd0, pc_wr}, 16'd1);
    checkOutput("lu_after.stall_cnt", stall_cnt, 16'd1);
    clockEdge();

    // Forwarding priority, WB fallback and $0 exclusion.
    mem_rw = 5'd7; wb_rw = 5'd7; ex_rs = 5'd7; ex_rt = 5'd7;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1; mem_memtoreg = 1'b0;
    settleAndCheck("fwd_mem");
    checkOutput("fwd_mem.fwd_a", {14'd0, fwd_a}, 16'd1);
    checkOutput("fwd_mem.fwd_b", {14'd0, fwd_b}, 16'd1);
    clockEdge();
    mem_reg_write = 1'b0;
    settleAndCheck("fwd_wb");
    checkOutput("fwd_wb.fwd_a", {14'd0, fwd_a}, 16'd2);
    clockEdge();
    ex_rs = 5'd0; mem_rw = 5'd0; wb_rw = 5'd0;
    settleAndCheck("fwd_r0");
    checkOutput("fwd_r0.fwd_a", {14'd0, fwd_a}, 16'd0);
    clockEdge();

    // Three-cycle memory wait, then ready.
    applyStimulus();
    reset = 1'b0;
    stepCycle("mw_rst");
    reset = 1'b1;
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      settleAndCheck("mw_wait");
      checkOutput("mw_wait.pc_wr", {15'd0, pc_wr}, 16'd0);
      checkOutput("mw_wait.mem_wb_flush", {15'd0, mem_wb_flush}, 16'd1);
      checkOutput("mw_wait.state", {15'd0, state}, (i == 1) ? 16'd0 : 16'd1);
      clockEdge();
    end
    dmem_ready = 1'b1;
    settleAndCheck("mw_ready");
    checkOutput("mw_ready.mem_wb_wrn", {15'd0, mem_wb_wrn}, 16'd1);
    clockEdge();
    applyStimulus();
    settleAndCheck("mw_done");
    checkOutput("mw_done.stall_cnt", stall_cnt, 16'd3);
    checkOutput("mw_done.state", {15'd0, state}, 16'd0);
    clockEdge();

    // Branch beats load-use; memory wait beats branch.
    branch_taken = 1'b1;
    ex_memtoreg = 1'b1; ex_reg_write = 1'b1; ex_rw = 5'd9;
    id_uses_rt = 1'b1; id_rt = 5'd9;
    settleAndCheck("pri_br");
    checkOutput("pri_br.pc_wr", {15'd0, pc_wr}, 16'd1);
    checkOutput("pri_br.if_id_flush", {15'd0, if_id_flush}, 16'd1);
    checkOutput("pri_br.id_exe_flush", {15'd0, id_exe_flush}, 16'd1);
    clockEdge();
    mem_req = 1'b1; dmem_ready = 1'b0;
    settleAndCheck("pri_mw");
    checkOutput("pri_mw.pc_wr", {15'd0, pc_wr}, 16'd0);
    checkOutput("pri_mw.flushes", {13'd0, if_id_flush, id_exe_flush, mem_wb_flush}, 16'd1);
    clockEdge();
    applyStimulus();
    stepCycle("pri_release");

    // Timeout after four waiting cycles, sticky until reset.
    reset = 1'b0;
    stepCycle("to_rst");
    reset = 1'b1;
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      settleAndCheck("to_wait");
      checkOutput("to_wait.mem_timeout", {15'd0, mem_timeout}, (i == 6) ? 16'd1 : 16'd0);
      clockEdge();
    end
    dmem_ready = 1'b1;
    stepCycle("to_ready");
    applyStimulus();
    settleAndCheck("to_sticky");
    checkOutput("to_sticky.mem_timeout", {15'd0, mem_timeout}, 16'd1);
    clockEdge();
    reset = 1'b0;
    stepCycle("to_clear_rst");
    reset = 1'b1;
    settleAndCheck("to_clear");
    checkOutput("to_clear.mem_timeout", {15'd0, mem_timeout}, 16'd0);
    clockEdge();

    // Reset in the middle of a memory wait.
    mem_req = 1'b1; dmem_ready = 1'b0;
    stepCycle("rmw_enter");
    stepCycle("rmw_wait");
    reset = 1'b0;
    settleAndCheck("rmw_rst");
    checkOutput("rmw_rst.enables",
                {11'd0, pc_wr, if_id_wrn, id_exe_wrn, exe_mem_wrn, mem_wb_wrn}, 16'd0);
    clockEdge();
    applyStimulus();
    settleAndCheck("rmw_after");
    checkOutput("rmw_after.state", {15'd0, state}, 16'd0);
    checkOutput("rmw_after.stall_cnt", stall_cnt, 16'd0);
    clockEdge();

    // Randomized traffic over a small register set so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 39) != 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom_range(0, 1));
      id_uses_rt    = 1'($urandom_range(0, 1));
      ex_rs         = 5'($urandom_range(0, 3));
      ex_rt         = 5'($urandom_range(0, 3));
      ex_rw         = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_memtoreg   = 1'($urandom_range(0, 1));
      mem_rw        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_memtoreg  = 1'($urandom_range(0, 1));
      wb_rw         = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      mem_req       = ($urandom_range(0, 2) == 0);
      dmem_ready    = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      stepCycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
